// File: rtl/teclado_pkg.sv
// Shared types and constants for the keypad emulator.
// Row/column patterns are active-low one-cold codes.
package teclado_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_BOUNCE,
        HOLD,
        RELEASE_BOUNCE
    } state_e;

    typedef enum logic [3:0] {
        KEY_0, KEY_1, KEY_2, KEY_3,
        KEY_4, KEY_5, KEY_6, KEY_7,
        KEY_8, KEY_9, KEY_A, KEY_B,
        KEY_C, KEY_D, KEY_E, KEY_F
    } key_e;

    localparam logic [3:0] POS_W = 4'b0111;
    localparam logic [3:0] POS_X = 4'b1011;
    localparam logic [3:0] POS_Y = 4'b1101;
    localparam logic [3:0] POS_Z = 4'b1110;
    localparam logic [3:0] HIGH  = 4'b1111;

endpackage

// File: rtl/teclado_key_pos.sv
// Key code to {row, column} position lookup.
// Layout: W=1 2 3 A, X=4 5 6 B, Y=7 8 9 C, Z=E 0 F D.
module teclado_key_pos
    import teclado_pkg::*;
(
    input  key_e       code_i,
    output logic [3:0] row_o,
    output logic [3:0] col_o
);

    always_comb begin
        {row_o, col_o} = {HIGH, HIGH};
        case (code_i)
            KEY_1:   {row_o, col_o} = {POS_W, POS_W};
            KEY_2:   {row_o, col_o} = {POS_W, POS_X};
            KEY_3:   {row_o, col_o} = {POS_W, POS_Y};
            KEY_A:   {row_o, col_o} = {POS_W, POS_Z};
            KEY_4:   {row_o, col_o} = {POS_X, POS_W};
            KEY_5:   {row_o, col_o} = {POS_X, POS_X};
            KEY_6:   {row_o, col_o} = {POS_X, POS_Y};
            KEY_B:   {row_o, col_o} = {POS_X, POS_Z};
            KEY_7:   {row_o, col_o} = {POS_Y, POS_W};
            KEY_8:   {row_o, col_o} = {POS_Y, POS_X};
            KEY_9:   {row_o, col_o} = {POS_Y, POS_Y};
            KEY_C:   {row_o, col_o} = {POS_Y, POS_Z};
            KEY_E:   {row_o, col_o} = {POS_Z, POS_W};
            KEY_0:   {row_o, col_o} = {POS_Z, POS_X};
            KEY_F:   {row_o, col_o} = {POS_Z, POS_Y};
            KEY_D:   {row_o, col_o} = {POS_Z, POS_Z};
            default: {row_o, col_o} = {HIGH, HIGH};
        endcase
    end

endmodule

// File: rtl/teclado_emulador.sv
// Matrix keypad emulator: press bounce, hold, release bounce,
// answering the scanner's row drive with the latched key's column.
module teclado_emulador
    import teclado_pkg::*;
#(
    parameter int BOUNCE_CYCLES = 40,
    parameter int BOUNCE_TOGGLE = 3,
    parameter int HOLD_CYCLES   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       press_req,
    input  logic       abort,
    input  logic [3:0] scan_in,
    output logic [3:0] cols_out,
    output logic       busy,
    output logic       done,
    output logic       key_down
);

    localparam bit          NO_BOUNCE = (BOUNCE_CYCLES == 0);
    localparam logic [15:0] B_LAST    = 16'(BOUNCE_CYCLES - 1);
    localparam logic [15:0] T_LAST    = 16'(BOUNCE_TOGGLE - 1);
    localparam logic [15:0] H_LAST    = 16'(HOLD_CYCLES - 1);

    state_e      state_q;
    key_e        code_q;
    logic        busy_q;
    logic        done_q;
    logic        key_down_q;
    logic [15:0] cnt_q;
    logic [15:0] tog_q;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        flip;
    logic        hit;

    teclado_key_pos u_pos (
        .code_i(code_q),
        .row_o (row),
        .col_o (col)
    );

    assign flip = (tog_q == T_LAST);

    // Any low scanner row overlapping the key's row closes the contact.
    assign hit      = key_down_q && ((~scan_in & ~row) != 4'b0000);
    assign cols_out = hit ? col : HIGH;
    assign busy     = busy_q;
    assign done     = done_q;
    assign key_down = key_down_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            code_q     <= KEY_0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            key_down_q <= 1'b0;
            cnt_q      <= '0;
            tog_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (press_req) begin
                        code_q     <= key_e'(key_code);
                        busy_q     <= 1'b1;
                        key_down_q <= 1'b1;
                        cnt_q      <= '0;
                        tog_q      <= '0;
                        state_q    <= NO_BOUNCE ? HOLD : PRESS_BOUNCE;
                    end
                end
                PRESS_BOUNCE, HOLD: begin
                    if (abort || (state_q == HOLD && cnt_q == H_LAST)) begin
                        key_down_q <= 1'b0;
                        cnt_q      <= '0;
                        tog_q      <= '0;
                        if (NO_BOUNCE) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RELEASE_BOUNCE;
                        end
                    end else if (state_q == HOLD) begin
                        cnt_q <= cnt_q + 16'd1;
                    end else if (cnt_q == B_LAST) begin
                        state_q    <= HOLD;
                        key_down_q <= 1'b1;
                        cnt_q      <= '0;
                        tog_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        tog_q <= flip ? '0 : tog_q + 16'd1;
                        if (flip) key_down_q <= ~key_down_q;
                    end
                end
                RELEASE_BOUNCE: begin
                    if (cnt_q == B_LAST) begin
                        state_q    <= IDLE;
                        key_down_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        cnt_q      <= '0;
                        tog_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        tog_q <= flip ? '0 : tog_q + 16'd1;
                        if (flip) key_down_q <= ~key_down_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/teclado_emulador.md
TECLADO_EMULADOR -- requirements
Module: teclado_emulador

Interface
REQ-001 SHALL have parameter BOUNCE_CYCLES, default 40, number of cycles in each press and release bounce window (0 = no bounce).
REQ-002 SHALL have parameter BOUNCE_TOGGLE, default 3, number of cycles between contact inversions while bouncing (≥1).
REQ-003 SHALL have parameter HOLD_CYCLES, default 1000, number of cycles of stable contact (1..65535).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port key_code, input, 4 bits: code of the key to press.
REQ-007 SHALL have port press_req, input, 1 bit: request to start a press, sampled in IDLE.
REQ-008 SHALL have port abort, input, 1 bit: forces early release.
REQ-009 SHALL have port scan_in, input, 4 bits: active-low row drive from the scanner.
REQ-010 SHALL have port cols_out, output, 4 bits: active-low column return to the scanner.
REQ-011 SHALL have port busy, output, 1 bit: high from acceptance until return to IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a press/release sequence completes.
REQ-013 SHALL have port key_down, output, 1 bit: current contact state.

Function
REQ-014 SHALL map keys to row/column positions, each position encoded as a 4-bit pattern (W=0111, X=1011, Y=1101, Z=1110); rows W: 1,2,3,A; X: 4,5,6,B; Y: 7,8,9,C; Z: E(*),0,F(#),D, with columns W,X,Y,Z in that order; all 16 codes are valid.
REQ-015 SHALL drive cols_out combinationally, with zero latency from scan_in: if key_down=1 and scan_in has a 0 in the latched key's row bit position, cols_out = the column pattern; otherwise cols_out = 1111. Multiple low rows in scan_in are allowed.
REQ-016 SHALL use FSM states IDLE, PRESS_BOUNCE, HOLD and RELEASE_BOUNCE.
REQ-017 IDLE: busy=0, key_down=0. On an edge with press_req=1, SHALL latch key_code, set busy<=1 and key_down<=1, clear the counters, and go to PRESS_BOUNCE (or to HOLD if BOUNCE_CYCLES=0).
REQ-018 PRESS_BOUNCE SHALL last exactly BOUNCE_CYCLES cycles; key_down SHALL invert every BOUNCE_TOGGLE cycles, starting from 1; on exit, key_down<=1 and the state goes to HOLD.
REQ-019 HOLD SHALL last exactly HOLD_CYCLES cycles with key_down=1; on exit, key_down<=0 and the state goes to RELEASE_BOUNCE (or to IDLE if BOUNCE_CYCLES=0).
REQ-020 RELEASE_BOUNCE SHALL last BOUNCE_CYCLES cycles, toggling key_down starting from 0; on exit, key_down<=0, busy<=0, done<=1 for exactly one cycle, and the state goes to IDLE.
REQ-021 abort=1 in PRESS_BOUNCE or HOLD SHALL move to RELEASE_BOUNCE (or IDLE with done if BOUNCE_CYCLES=0) on the next edge, with key_down<=0; abort SHALL be ignored in IDLE and RELEASE_BOUNCE.
REQ-022 press_req while busy=1 SHALL be ignored; the latched code SHALL be unchanged.
REQ-023 press_req=1 and abort=1 together in IDLE SHALL start a press normally.
REQ-024 SHALL use 16-bit cycle and toggle counters; counters SHALL never wrap within a state.

Reset
REQ-025 On rst=0, SHALL immediately set state=IDLE, key_down=0, busy=0, done=0, cols_out=1111, latched code=0, counters=0, including when reset occurs mid-sequence.
REQ-026 After rst is released, SHALL accept no press until the first edge with press_req=1.

Structure
REQ-027 Package teclado_pkg SHALL hold the state enum, the row/column patterns W/X/Y/Z, the key-code enum and HIGH=4'b1111.
REQ-028 Sub-module teclado_key_pos SHALL perform the combinational code→{row pattern, column pattern} lookup.

Verification (BOUNCE_CYCLES=6, BOUNCE_TOGGLE=2, HOLD_CYCLES=10 unless stated)
REQ-029 key_code=5, press_req pulse, scan_in=1011 → cols_out 1011,1011,1111,1111,1011,1011; then 1011 for 10 cycles; then 6 release-bounce cycles starting at 1111; then a single done pulse and busy=0.
REQ-030 key_code=E, scan_in cycling 0111/1011/1101/1110 during HOLD → cols_out=0111 only while scan_in=1110, otherwise 1111.
REQ-031 key_code=2 press_req asserted again during busy → ignored; exactly one done; cols_out follows the original key.
REQ-032 abort=1 in the 3rd HOLD cycle → next cycle key_down=0 (RELEASE_BOUNCE); done 6 cycles later.
REQ-033 rst=0 in mid-HOLD → cols_out=1111, busy=0, done=0 without waiting for a clock edge.
REQ-034 BOUNCE_CYCLES=0, key_code=D, scan_in=1110 → cols_out=1110 from the cycle after acceptance for exactly 10 cycles, then done.
